// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// Optional single-cycle multiply: define MULDIV_FAST_MULT_EN.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic             rd_req,
  input  logic             flush,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic             is_div_q, is_div_d;
  logic             neg_q, neg_d;
  logic             rneg_q, rneg_d;
  logic             div0_q, div0_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;

  logic             is_signed;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_sh;
  logic [WIDTH:0]   div_diff;
  logic             div_ge;
  logic [2*WIDTH-1:0] prod_raw, prod_fix;
  logic [WIDTH-1:0] quot_fix, rem_fix;
`ifdef MULDIV_FAST_MULT_EN
  logic [2*WIDTH-1:0] fast_prod;
`endif

  // Operands are reduced to magnitudes; signs are reapplied in DONE.
  always_comb begin
    is_signed = ~op[0];
    a_neg     = is_signed & a[WIDTH-1];
    b_neg     = is_signed & b[WIDTH-1];
    a_mag     = a_neg ? -a : a;
    b_mag     = b_neg ? -b : b;
`ifdef MULDIV_FAST_MULT_EN
    fast_prod = (2*WIDTH)'(a_mag) * (2*WIDTH)'(b_mag);
`endif
  end

  // Datapath steps: acc holds product-high / remainder, sh holds multiplier-then-product-low / dividend-then-quotient.
  always_comb begin
    mul_sum  = {1'b0, acc_q} + (sh_q[0] ? {1'b0, opnd_q} : '0);
    div_sh   = {acc_q, sh_q[WIDTH-1]};
    div_ge   = (div_sh >= {1'b0, opnd_q});
    div_diff = div_sh - {1'b0, opnd_q};
    prod_raw = {acc_q, sh_q};
    prod_fix = neg_q ? -prod_raw : prod_raw;
    quot_fix = div0_q ? '1 : (neg_q ? -sh_q : sh_q);
    rem_fix  = rneg_q ? -acc_q : acc_q;
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    acc_d    = acc_q;
    sh_d     = sh_q;
    opnd_d   = opnd_q;
    is_div_d = is_div_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    div0_d   = div0_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!flush) begin
          if (mthi) hi_d = a;
          if (mtlo) lo_d = a;
          if (start) begin
            is_div_d = op[1];
            neg_d    = a_neg ^ b_neg;
            rneg_d   = a_neg;
            div0_d   = op[1] & (b == '0);
            count_d  = CW'(WIDTH - 1);
            acc_d    = '0;
            state_d  = S_RUN;
            if (op[1]) begin
              sh_d   = a_mag;
              opnd_d = b_mag;
            end else begin
              sh_d   = b_mag;
              opnd_d = a_mag;
            end
`ifdef MULDIV_FAST_MULT_EN
            if (!op[1]) begin
              {acc_d, sh_d} = fast_prod;
              state_d       = S_DONE;
            end
`endif
          end
        end
      end
      S_RUN: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          if (is_div_q) begin
            acc_d = div_ge ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0];
            sh_d  = {sh_q[WIDTH-2:0], div_ge};
          end else begin
            acc_d = mul_sum[WIDTH:1];
            sh_d  = {mul_sum[0], sh_q[WIDTH-1:1]};
          end
          if (count_q == '0) state_d = S_DONE;
          else               count_d = count_q - CW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        if (!flush) begin
          hi_d   = is_div_q ? rem_fix  : prod_fix[2*WIDTH-1:WIDTH];
          lo_d   = is_div_q ? quot_fix : prod_fix[WIDTH-1:0];
          done_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      count_q  <= '0;
      acc_q    <= '0;
      sh_q     <= '0;
      opnd_q   <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      div0_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      acc_q    <= acc_d;
      sh_q     <= sh_d;
      opnd_q   <= opnd_d;
      is_div_q <= is_div_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      div0_q   <= div0_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

  assign busy  = (state_q != S_IDLE);
  assign stall = busy & (start | rd_req | mthi | mtlo);
  assign done  = done_q;
  assign hi    = hi_q;
  assign lo    = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: stimulus pushes expected {hi,lo}, a monitor checks on each done pulse.
module tb_muldiv_unit;
  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             reset;
  logic             start, mthi, mtlo, rd_req, flush;
  logic [1:0]       op;
  logic [WIDTH-1:0] a, b;
  logic             busy, stall, done;
  logic [WIDTH-1:0] hi, lo;

  int checks = 0;
  int errors = 0;
  logic [2*WIDTH-1:0] sb[$];

  muldiv_unit #(.WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .mthi(mthi), .mtlo(mtlo), .rd_req(rd_req), .flush(flush),
    .busy(busy), .stall(stall), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest expected result.
  always @(negedge clk) begin
    if (reset === 1'b1 && done === 1'b1) begin
      if (sb.size() == 0) chk("unexpected_done", {63'b0, done}, 64'd0);
      else                chk("result_hilo", {hi, lo}, sb.pop_front());
    end
  end

  task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] eh, input logic [31:0] el, input string nm);
    int lat, n;
    bit seen;
    lat = WIDTH + 1;
`ifdef MULDIV_FAST_MULT_EN
    if (!o[1]) lat = 1;
`endif
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    sb.push_back({eh, el});
    @(posedge clk);
    #1 start = 1'b0;
    n = 0; seen = 0;
    while (!seen && n < 40) begin
      @(posedge clk); n++;
      @(negedge clk);
      if (done) seen = 1;
    end
    chk({nm, "_latency"}, 64'(n), 64'(lat));
    chk({nm, "_busy_low"}, {63'b0, busy}, 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; start = 0; mthi = 0; mtlo = 0; rd_req = 0; flush = 0;
    op = 2'b00; a = '0; b = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy",  {63'b0, busy},  64'd0);
    chk("rst_done",  {63'b0, done},  64'd0);
    chk("rst_stall", {63'b0, stall}, 64'd0);
    chk("rst_hilo",  {hi, lo},       64'd0);
    reset = 1'b1;

    do_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, "multu_max");
    do_op(2'b00, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, "mult_neg3x5");
    do_op(2'b00, 32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFF2, "mult_7xneg2");
    do_op(2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, "div_neg7_2");
    do_op(2'b10, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, "div_7_neg2");
    do_op(2'b11, 32'h0000000A, 32'h00000000, 32'h0000000A, 32'hFFFFFFFF, "divu_by0");
    do_op(2'b10, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF, "div_by0");
    do_op(2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, "div_ovf");
    do_op(2'b11, 32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E, "divu_100_7");

    // Stall window: DIVU 20/3, rd_req from edge 5, ignored start at 10, ignored mthi at 12.
    @(negedge clk);
    start = 1'b1; op = 2'b11; a = 32'd20; b = 32'd3;
    sb.push_back({32'd2, 32'd6});
    for (int e = 1; e <= 34; e++) begin
      @(negedge clk);
      start = (e == 10);
      if (e == 10) begin op = 2'b11; a = 32'd1; b = 32'd1; end
      mthi = (e == 12);
      if (e == 12) a = 32'hDEADBEEF;
      if (e == 5) rd_req = 1'b1;
      #1;
      if (e == 5 || e == 10 || e == 12 || e == 33)
        chk($sformatf("stall_busy_e%0d", e), {63'b0, stall}, 64'd1);
      if (e == 34) begin
        chk("stall_idle", {63'b0, stall}, 64'd0);
        rd_req = 1'b0;
      end
    end
    start = 0; mthi = 0;
    repeat (40) @(negedge clk);
    chk("stall_no_extra_op", 64'(sb.size()), 64'd0);
    chk("stall_mthi_ignored", {32'b0, hi}, 64'd2);

    // mthi/mtlo, then a DIV squashed by flush at edge 7.
    @(negedge clk);
    a = 32'h12345678; mthi = 1; mtlo = 1;
    @(negedge clk);
    mthi = 0; mtlo = 0;
    chk("mt_hilo", {hi, lo}, {32'h12345678, 32'h12345678});
    start = 1'b1; op = 2'b10; a = 32'd100; b = 32'd3;
    for (int e = 1; e <= 7; e++) begin
      @(negedge clk);
      start = 1'b0;
      flush = (e == 7);
    end
    @(negedge clk);
    flush = 1'b0;
    chk("flush_busy", {63'b0, busy}, 64'd0);
    chk("flush_hilo", {hi, lo}, {32'h12345678, 32'h12345678});
    a = 32'h0; mthi = 1; start = 1; op = 2'b01; flush = 1;
    @(negedge clk);
    mthi = 0; start = 0; flush = 0;
    chk("flush_blocks_mthi", {32'b0, hi}, {32'b0, 32'h12345678});
    chk("flush_blocks_start", {63'b0, busy}, 64'd0);
    repeat (40) @(negedge clk);

    // Asynchronous reset in the middle of a MULT.
    start = 1'b1; op = 2'b00; a = 32'd5; b = 32'd6;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (12) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_hilo", {hi, lo}, 64'd0);
    chk("async_rst_busy", {63'b0, busy}, 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    do_op(2'b01, 32'h00000003, 32'h00000004, 32'h00000000, 32'h0000000C, "multu_after_rst");

    repeat (3) @(negedge clk);
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
